// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle RV32I control FSM sharing one valid/ready memory port
module multicycle_control_unit #(
  parameter int ALU_CTRL_W = 3,
  parameter bit EXT_ALU = 1'b0,
  parameter bit EXT_BRANCH = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal,
  output logic                  retire
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
  } state_t;
  localparam logic [1:0] RS_ALUOUT = 2'd0, RS_MEM = 2'd1, RS_ALU = 2'd2;
  localparam logic [1:0] SA_PC = 2'd0, SA_OLD = 2'd1, SA_RD1 = 2'd2;
  localparam logic [1:0] SB_RD2 = 2'd0, SB_IMM = 2'd1, SB_4 = 2'd2;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0), ALU_SUB = ALU_CTRL_W'(1),
    ALU_AND = ALU_CTRL_W'(2), ALU_OR = ALU_CTRL_W'(3), ALU_XOR = ALU_CTRL_W'(4),
    ALU_SLT = ALU_CTRL_W'(5), ALU_SLTU = ALU_CTRL_W'(6), ALU_SLL = ALU_CTRL_W'(7),
    ALU_SRL = ALU_CTRL_W'(8), ALU_SRA = ALU_CTRL_W'(9);
  state_t state, next;
  logic r_ok, i_ok, br_ok, taken;
  logic [ALU_CTRL_W-1:0] r_op, i_op;
  always_ff @(posedge clk) state <= rst_n ? next : FETCH;
  always_comb begin
    r_ok = 1'b1;
    r_op = ALU_ADD;
    case ({funct7, funct3})
      {7'h00, 3'b000}: r_op = ALU_ADD;
      {7'h20, 3'b000}: r_op = ALU_SUB;
      {7'h00, 3'b010}: r_op = ALU_SLT;
      {7'h00, 3'b110}: r_op = ALU_OR;
      {7'h00, 3'b111}: r_op = ALU_AND;
      {7'h00, 3'b100}: begin r_op = ALU_XOR; r_ok = EXT_ALU; end
      {7'h00, 3'b001}: begin r_op = ALU_SLL; r_ok = EXT_ALU; end
      {7'h00, 3'b101}: begin r_op = ALU_SRL; r_ok = EXT_ALU; end
      {7'h20, 3'b101}: begin r_op = ALU_SRA; r_ok = EXT_ALU; end
      {7'h00, 3'b011}: begin r_op = ALU_SLTU; r_ok = EXT_ALU; end
      default: r_ok = 1'b0;
    endcase
    // Only ADDI is in the base set; funct7[5] selects the shift flavour
    i_ok = EXT_ALU;
    case (funct3)
      3'b000: begin i_op = ALU_ADD; i_ok = 1'b1; end
      3'b001: begin i_op = ALU_SLL; i_ok = EXT_ALU && !funct7[5]; end
      3'b010: i_op = ALU_SLT;
      3'b011: i_op = ALU_SLTU;
      3'b100: i_op = ALU_XOR;
      3'b110: i_op = ALU_OR;
      3'b111: i_op = ALU_AND;
      default: i_op = funct7[5] ? ALU_SRA : ALU_SRL;
    endcase
    br_ok = EXT_BRANCH;
    taken = 1'b0;
    case (funct3)
      3'b000: begin br_ok = 1'b1; taken = zero; end
      3'b001: taken = !zero;
      3'b100: taken = lt;
      3'b101: taken = !lt;
      3'b110: taken = ltu;
      3'b111: taken = !ltu;
      default: br_ok = 1'b0;
    endcase
  end
  always_comb begin
    next = state;
    mem_req = 1'b0;
    mem_write = 1'b0;
    adr_src = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    reg_write = 1'b0;
    result_src = RS_ALUOUT;
    alu_src_a = SA_PC;
    alu_src_b = SB_RD2;
    imm_src = IMM_I;
    alu_control = ALU_ADD;
    illegal = 1'b0;
    retire = 1'b0;
    // Everything stays at zero while reset is held
    if (rst_n)
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          alu_src_b = SB_4;
          result_src = RS_ALU;
          ir_write = mem_ready;
          pc_write = mem_ready;
          next = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          alu_src_a = SA_OLD;
          alu_src_b = SB_IMM;
          imm_src = IMM_B;
          next = (opcode == 7'b0000011 || opcode == 7'b0100011) ? MEMADR :
                 opcode == 7'b0110011 ? EXECR :
                 opcode == 7'b0010011 ? EXECI :
                 opcode == 7'b1100011 ? BRANCH :
                 opcode == 7'b1101111 ? JAL : TRAP;
        end
        MEMADR: begin
          alu_src_a = SA_RD1;
          alu_src_b = SB_IMM;
          imm_src = opcode[5] ? IMM_S : IMM_I;
          next = opcode[5] ? MEMWRITE : MEMREAD;
        end
        MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          next = mem_ready ? MEMWB : MEMREAD;
        end
        MEMWB: begin
          result_src = RS_MEM;
          reg_write = 1'b1;
          retire = 1'b1;
          next = FETCH;
        end
        MEMWRITE: begin
          mem_req = 1'b1;
          mem_write = 1'b1;
          adr_src = 1'b1;
          retire = mem_ready;
          next = mem_ready ? FETCH : MEMWRITE;
        end
        EXECR: begin
          alu_src_a = SA_RD1;
          alu_control = r_op;
          next = r_ok ? ALUWB : TRAP;
        end
        EXECI: begin
          alu_src_a = SA_RD1;
          alu_src_b = SB_IMM;
          alu_control = i_op;
          next = i_ok ? ALUWB : TRAP;
        end
        ALUWB: begin
          reg_write = 1'b1;
          retire = 1'b1;
          next = FETCH;
        end
        BRANCH: begin
          alu_src_a = SA_RD1;
          alu_control = ALU_SUB;
          pc_write = br_ok && taken;
          retire = br_ok;
          next = br_ok ? FETCH : TRAP;
        end
        JAL: begin
          alu_src_a = SA_OLD;
          alu_src_b = SB_4;
          pc_write = 1'b1;
          next = ALUWB;
        end
        TRAP: begin
          illegal = 1'b1;
          next = FETCH;
        end
        default: next = FETCH;
      endcase
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: random instruction stream vs. an instruction-level model, base and extended builds
module tb_multicycle_control_unit;
  localparam logic [3:0] A_ADD = 0, A_SUB = 1, A_AND = 2, A_OR = 3, A_XOR = 4,
    A_SLT = 5, A_SLTU = 6, A_SLL = 7, A_SRL = 8, A_SRA = 9;
  localparam logic [9:0] RKEY [10] = '{10'h000, 10'h100, 10'h002, 10'h006, 10'h007,
                                       10'h004, 10'h001, 10'h005, 10'h105, 10'h003};
  localparam logic [3:0] RCODE [10] = '{A_ADD, A_SUB, A_SLT, A_OR, A_AND,
                                        A_XOR, A_SLL, A_SRL, A_SRA, A_SLTU};
  localparam bit RISX [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  localparam logic [3:0] ICODE [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
  localparam logic [6:0] BADOP [5] = '{7'h37, 7'h17, 7'h67, 7'h73, 7'h00};
  typedef struct packed {
    int lat; int xf; int rw; int pcw; int mw; int ill; int ret; int rs; int alu; bit ca;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
  logic [6:0] opcode = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic zero = 0, lt = 0, ltu = 0, mem_ready = 0;
  logic rst0_n, rst1_n;
  logic q0, w0, as0, ir0, pc0, rw0, il0, rt0, q1, w1, as1, ir1, pc1, rw1, il1, rt1;
  logic [1:0] rs0, sa0, sb0, rs1, sa1, sb1;
  logic [2:0] im0, im1, al0;
  logic [3:0] al1;
  logic o_req, o_mw, o_as, o_irw, o_pcw, o_rw, o_ill, o_ret;
  logic [1:0] o_rs, o_sa, o_sb;
  logic [2:0] o_im;
  logic [3:0] o_alu;
  logic [20:0] strobes;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  assign rst0_n = rst_n && !sel;
  assign rst1_n = rst_n && sel;
  multicycle_control_unit #(.ALU_CTRL_W(3), .EXT_ALU(1'b0), .EXT_BRANCH(1'b0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready), .mem_req(q0), .mem_write(w0),
    .adr_src(as0), .ir_write(ir0), .pc_write(pc0), .reg_write(rw0), .result_src(rs0),
    .alu_src_a(sa0), .alu_src_b(sb0), .imm_src(im0), .alu_control(al0), .illegal(il0),
    .retire(rt0));
  multicycle_control_unit #(.ALU_CTRL_W(4), .EXT_ALU(1'b1), .EXT_BRANCH(1'b1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready), .mem_req(q1), .mem_write(w1),
    .adr_src(as1), .ir_write(ir1), .pc_write(pc1), .reg_write(rw1), .result_src(rs1),
    .alu_src_a(sa1), .alu_src_b(sb1), .imm_src(im1), .alu_control(al1), .illegal(il1),
    .retire(rt1));
  assign o_req = sel ? q1 : q0;
  assign o_mw = sel ? w1 : w0;
  assign o_as = sel ? as1 : as0;
  assign o_irw = sel ? ir1 : ir0;
  assign o_pcw = sel ? pc1 : pc0;
  assign o_rw = sel ? rw1 : rw0;
  assign o_ill = sel ? il1 : il0;
  assign o_ret = sel ? rt1 : rt0;
  assign o_rs = sel ? rs1 : rs0;
  assign o_sa = sel ? sa1 : sa0;
  assign o_sb = sel ? sb1 : sb0;
  assign o_im = sel ? im1 : im0;
  assign o_alu = sel ? al1 : {1'b0, al0};
  assign strobes = {o_req, o_mw, o_as, o_irw, o_pcw, o_rw, o_ill, o_ret, o_rs, o_sa, o_sb, o_im, o_alu};
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s (ext=%0d op=%h f3=%0d f7=%h): got %0d expected %0d",
                  tag, sel, opcode, funct3, funct7, got, exp);
  endtask
  function automatic int rcode(input logic [6:0] f7, input logic [2:0] f3, input bit ext);
    for (int i = 0; i < 10; i++)
      if (RKEY[i] == {f7, f3} && (ext || !RISX[i])) return int'(RCODE[i]);
    return -1;
  endfunction
  function automatic int icode(input logic [6:0] f7, input logic [2:0] f3, input bit ext);
    if (f3 == 3'd0) return int'(A_ADD);
    if (!ext || (f3 == 3'd1 && f7[5])) return -1;
    if (f3 == 3'd5 && f7[5]) return int'(A_SRA);
    return int'(ICODE[f3]);
  endfunction
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input bit ext, input logic z, input logic l, input logic lu);
    exp_t e;
    int c;
    e = '0;
    e.xf = 1;
    e.ret = 1;
    case (op)
      7'h03: begin e.lat = 5; e.xf = 2; e.rw = 1; e.rs = 1; e.alu = A_ADD; e.ca = 1; end
      7'h23: begin e.lat = 4; e.xf = 2; e.mw = 1; e.alu = A_ADD; e.ca = 1; end
      7'h33, 7'h13: begin
        c = (op == 7'h33) ? rcode(f7, f3, ext) : icode(f7, f3, ext);
        e.lat = 4;
        if (c < 0) begin e.ill = 1; e.ret = 0; end
        else begin e.rw = 1; e.alu = c; e.ca = 1; end
      end
      7'h63: begin
        if (f3 == 3'd0 || (ext && f3 != 3'd2 && f3 != 3'd3)) begin
          e.lat = 3;
          e.pcw = int'((f3[2] ? (f3[1] ? lu : l) : z) ^ f3[0]);
          e.alu = A_SUB;
          e.ca = 1;
        end else begin e.lat = 4; e.ill = 1; e.ret = 0; end
      end
      7'h6F: begin e.lat = 4; e.rw = 1; e.pcw = 1; e.alu = A_ADD; e.ca = 1; end
      default: begin e.lat = 3; e.ill = 1; e.ret = 0; end
    endcase
    return e;
  endfunction
  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic z, input logic l, input logic lu, input int pct);
    exp_t e;
    int cyc = 0, stalls = 0, xf = 0, rw = 0, pcw = 0, fpc = 0, mw = 0, bad = 0;
    int ill = 0, ret = 0, irw = 0, rs = -1, alu = -1, age = -1;
    bit done = 0;
    opcode = op; funct3 = f3; funct7 = f7; zero = z; lt = l; ltu = lu;
    e = model(op, f3, f7, sel, z, l, lu);
    while (!done && cyc < 64) begin
      mem_ready = ($urandom_range(99) < pct);
      #1;
      cyc++;
      if (o_req && !mem_ready) stalls++;
      if (o_req && mem_ready) xf++;
      if (o_mw && !o_req) bad++;
      if (o_mw && o_req && mem_ready) mw++;
      if (o_rw) begin rw++; rs = o_rs; end
      if (o_pcw && o_irw) fpc++;
      if (o_pcw && !o_irw) pcw++;
      if (o_ill) ill++;
      if (o_ret) ret++;
      if (age >= 0) age++;
      if (o_irw) begin irw++; age = 0; end
      if (age == 2) alu = o_alu;
      done = o_ret || o_ill;
      @(negedge clk);
    end
    check("done", int'(done), 1);
    check("cycles", cyc, e.lat + stalls);
    check("transfers", xf, e.xf);
    check("ir_write", irw, 1);
    check("fetch_pc_write", fpc, 1);
    check("pc_write", pcw, e.pcw);
    check("reg_write", rw, e.rw);
    check("store_xfer", mw, e.mw);
    check("mem_write_no_req", bad, 0);
    check("illegal", ill, e.ill);
    check("retire", ret, e.ret);
    if (e.rw != 0) check("result_src", rs, e.rs);
    if (e.ca) check("alu_control", alu, e.alu);
  endtask
  task automatic random_instr();
    logic [6:0] op, f7;
    case ($urandom_range(6))
      0: op = 7'h03;
      1: op = 7'h23;
      2: op = 7'h33;
      3: op = 7'h13;
      4: op = 7'h63;
      5: op = 7'h6F;
      default: op = BADOP[$urandom_range(4)];
    endcase
    f7 = ($urandom_range(3) == 0) ? 7'($urandom) : ($urandom_range(1) ? 7'h20 : 7'h00);
    run(op, 3'($urandom), f7, 1'($urandom), 1'($urandom), 1'($urandom),
        $urandom_range(1) ? 100 : 50);
  endtask
  task automatic reset_midway();
    int rws = 0;
    opcode = 7'h03; funct3 = 3'b010; funct7 = 7'h00; mem_ready = 1'b1;
    repeat (3) begin #1 rws += int'(o_rw); @(negedge clk); end
    mem_ready = 1'b0;
    repeat (2) begin #1 check("memread_wait", int'({o_req, o_as, o_rw}), 6); @(negedge clk); end
    rst_n = 1'b0;
    repeat (2) begin
      mem_ready = 1'($urandom);
      #1 check("reset_strobes", int'(strobes), 0);
      rws += int'(o_rw);
      @(negedge clk);
    end
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1 check("refetch_after_reset", int'({o_req, o_as, o_rs, o_sb}), 'b1_0_10_10);
    rws += int'(o_rw);
    check("abort_no_write", rws, 0);
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #1 check("reset_strobes_base", int'(strobes), 0);
    sel = 1'b1;
    #1 check("reset_strobes_ext", int'(strobes), 0);
    for (int p = 0; p < 2; p++) begin
      sel = p[0];
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b0;
      #1 check("reset_fetch", int'({o_req, o_mw, o_as, o_rs, o_sa, o_sb}), 'b1_0_0_10_00_10);
      @(negedge clk);
      run(7'h03, 3'b010, 7'h00, 0, 0, 0, 100);
      run(7'h23, 3'b010, 7'h00, 0, 0, 0, 40);
      run(7'h63, 3'b000, 7'h00, 1, 0, 0, 100);
      run(7'h63, 3'b000, 7'h00, 0, 0, 0, 100);
      run(7'h63, 3'b001, 7'h00, 0, 0, 0, 100);
      run(7'h63, 3'b111, 7'h00, 0, 0, 1, 100);
      run(7'h33, 3'b000, 7'h20, 0, 0, 0, 100);
      run(7'h33, 3'b100, 7'h00, 0, 0, 0, 100);
      run(7'h13, 3'b101, 7'h20, 0, 0, 0, 100);
      run(7'h6F, 3'b101, 7'h00, 0, 0, 0, 100);
      run(7'h37, 3'b000, 7'h00, 0, 0, 0, 100);
      repeat (80) random_instr();
      reset_midway();
      repeat (10) random_instr();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
